apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_req_arbiter.sv | 155 +++++++++++++++
 tb/tb_apb_req_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share a single APB master port.
// Define APB_ARB_PREADY_EN to add the pready input and allow slave wait states.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | bus idle; a valid requester is granted by round-robin
// S_SETUP  | APB setup phase: psel=1, penable=0, lasts one cycle
// S_ACCESS | APB access phase: penable=1 until the transfer is done
module apb_req_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ack,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic [AW-1:0]      paddr,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [DW-1:0]      pwdata,
`ifdef APB_ARB_PREADY_EN
  input  logic               pready,
`endif
  input  logic [DW-1:0]      prdata
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t          state_q;
  logic [GW-1:0]   last_grant_q;
  logic [AW-1:0]   paddr_q;
  logic [DW-1:0]   pwdata_q;
  logic            pwrite_q;
  logic            psel_q;
  logic            penable_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [DW-1:0]   rsp_rdata_q;

  logic [AW-1:0]   addr_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];

  logic            xfer_done;
  logic            grant_en;
  logic            pick_found;
  logic [GW-1:0]   pick_idx;
  logic [GW-1:0]   cand;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*AW +: AW];
    assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
  end

`ifdef APB_ARB_PREADY_EN
  assign xfer_done = pready;
`else
  assign xfer_done = 1'b1;
`endif

  // Walk offsets from farthest to nearest so the requester closest after
  // last_grant_q overwrites any earlier hit.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = GW'((int'(last_grant_q) + k) % NREQ);
      if (req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign grant_en = (state_q == S_IDLE) || ((state_q == S_ACCESS) && xfer_done);
  assign req_ack  = (grant_en && pick_found) ? (NREQ'(1) << pick_idx) : '0;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q      <= S_IDLE;
      last_grant_q <= GW'(NREQ - 1);
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pwrite_q     <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            paddr_q      <= addr_arr[pick_idx];
            pwdata_q     <= wdata_arr[pick_idx];
            pwrite_q     <= req_write[pick_idx];
            last_grant_q <= pick_idx;
            psel_q       <= 1'b1;
            penable_q    <= 1'b0;
            state_q      <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (xfer_done) begin
            rsp_valid_q <= NREQ'(1) << last_grant_q;
            if (!pwrite_q) rsp_rdata_q <= prdata;
            if (pick_found) begin
              paddr_q      <= addr_arr[pick_idx];
              pwdata_q     <= wdata_arr[pick_idx];
              pwrite_q     <= req_write[pick_idx];
              last_grant_q <= pick_idx;
              psel_q       <= 1'b1;
              penable_q    <= 1'b0;
              state_q      <= S_SETUP;
            end else begin
              psel_q    <= 1'b0;
              penable_q <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pwrite    = pwrite_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter (NREQ=2); wait-state steps are built
// only when APB_ARB_PREADY_EN is defined.
module tb_apb_req_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic             pclk;
  logic             presetn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ack;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic [AW-1:0]      paddr;
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [DW-1:0]      pwdata;
  logic [DW-1:0]      prdata;
`ifdef APB_ARB_PREADY_EN
  logic               pready;
`endif

  int checks   = 0;
  int failures = 0;

  apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ack   (req_ack),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
`ifdef APB_ARB_PREADY_EN
    .pready    (pready),
`endif
    .prdata    (prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    presetn   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    prdata    = '0;
`ifdef APB_ARB_PREADY_EN
    pready    = 1'b1;
`endif
    tick(); tick();
    #1;
    chk("rst_psel",      psel,      1'b0);
    chk("rst_penable",   penable,   1'b0);
    chk("rst_paddr",     paddr,     '0);
    chk("rst_pwrite",    pwrite,    1'b0);
    chk("rst_pwdata",    pwdata,    '0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    tick();
    presetn = 1'b1;
    tick();

    // single write from requester 0
    req_valid = 2'b01;
    req_write = 2'b01;
    req_addr[0*AW +: AW]  = 32'h0000_0010;
    req_wdata[0*DW +: DW] = 32'hA5A5_0001;
    #1;
    chk("wr_ack_c0", req_ack, 2'b01);
    tick();
    req_valid = 2'b11;
    #1;
    chk("wr_setup_psel",    psel,    1'b1);
    chk("wr_setup_penable", penable, 1'b0);
    chk("wr_setup_paddr",   paddr,   32'h10);
    chk("wr_setup_pwrite",  pwrite,  1'b1);
    chk("wr_setup_pwdata",  pwdata,  32'hA5A5_0001);
    chk("wr_setup_ack0",    req_ack, 2'b00);
    req_valid = 2'b00;
    tick();
    chk("wr_access_penable", penable, 1'b1);
    chk("wr_access_paddr",   paddr,   32'h10);
    chk("wr_access_rsp",     rsp_valid, 2'b00);
    tick();
    chk("wr_rsp_valid", rsp_valid, 2'b01);
    chk("wr_idle_psel", psel,      1'b0);
    chk("wr_idle_pen",  penable,   1'b0);
    tick();
    chk("wr_rsp_pulse", rsp_valid, 2'b00);

    // single read from requester 1
    req_valid = 2'b10;
    req_write = 2'b00;
    req_addr[1*AW +: AW] = 32'h0000_0020;
    prdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_ack_c0", req_ack, 2'b10);
    tick();
    req_valid = 2'b00;
    #1;
    chk("rd_setup_paddr",  paddr,  32'h20);
    chk("rd_setup_pwrite", pwrite, 1'b0);
    tick();
    chk("rd_access_pen", penable, 1'b1);
    tick();
    chk("rd_rsp_valid", rsp_valid, 2'b10);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    tick();

    // contention: both write back-to-back, grants 0,1,0,1
    req_valid = 2'b11;
    req_write = 2'b11;
    req_addr[0*AW +: AW] = 32'h0000_0100;
    req_addr[1*AW +: AW] = 32'h0000_0104;
    prdata = 32'h1234_5678;
    #1;
    chk("ct_ack_c0", req_ack, 2'b01);
    tick();
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("ct%0d_psel", n),    psel,    1'b1);
      chk($sformatf("ct%0d_penable", n), penable, 1'b0);
      chk($sformatf("ct%0d_paddr", n),   paddr,   (n % 2 == 0) ? 32'h100 : 32'h104);
      chk($sformatf("ct%0d_ack_setup", n), req_ack, 2'b00);
      if (n > 0) chk($sformatf("ct%0d_prev_rsp", n), rsp_valid, (n % 2 == 1) ? 2'b01 : 2'b10);
      if (n == 3) req_valid = 2'b00;
      tick();
      chk($sformatf("ct%0d_access_psel", n), psel,    1'b1);
      chk($sformatf("ct%0d_access_pen", n),  penable, 1'b1);
      chk($sformatf("ct%0d_access_ack", n),  req_ack,
          (n == 3) ? 2'b00 : ((n % 2 == 0) ? 2'b10 : 2'b01));
      tick();
    end
    chk("ct_last_rsp",   rsp_valid, 2'b10);
    chk("ct_idle_psel",  psel,      1'b0);
    chk("ct_rdata_held", rsp_rdata, 32'hDEAD_BEEF);
    tick();

`ifdef APB_ARB_PREADY_EN
    // wait states: pready low for 3 ACCESS cycles
    req_valid = 2'b01;
    req_write = 2'b00;
    req_addr[0*AW +: AW] = 32'h0000_0040;
    pready = 1'b0;
    prdata = 32'h0BAD_F00D;
    #1;
    chk("ws_ack_c0", req_ack, 2'b01);
    tick();
    tick();
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("ws%0d_pen", w),   penable,   1'b1);
      chk($sformatf("ws%0d_paddr", w), paddr,     32'h40);
      chk($sformatf("ws%0d_rsp", w),   rsp_valid, 2'b00);
      chk($sformatf("ws%0d_ack", w),   req_ack,   2'b00);
      tick();
    end
    req_valid = 2'b00;
    pready = 1'b1;
    #1;
    chk("ws_last_pen",   penable, 1'b1);
    chk("ws_last_paddr", paddr,   32'h40);
    tick();
    chk("ws_rsp_valid", rsp_valid, 2'b01);
    chk("ws_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
    chk("ws_idle_pen",  penable,   1'b0);
    tick();
    chk("ws_rsp_pulse", rsp_valid, 2'b00);
    // leave last_grant at 1 for the reset step below
    req_valid = 2'b10;
    req_write = 2'b11;
    tick();
    req_valid = 2'b00;
    tick(); tick(); tick();
`endif

    // reset during ACCESS of a read to 0x30 by requester 0
    req_valid = 2'b01;
    req_write = 2'b00;
    req_addr[0*AW +: AW] = 32'h0000_0030;
    prdata = 32'hCAFE_0030;
    #1;
    chk("rs_ack_c0", req_ack, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    chk("rs_access_pen",   penable, 1'b1);
    chk("rs_access_paddr", paddr,   32'h30);
    #1;
    presetn = 1'b0;
    #1;
    chk("rs_abort_psel",    psel,    1'b0);
    chk("rs_abort_penable", penable, 1'b0);
    chk("rs_abort_paddr",   paddr,   '0);
    tick();
    chk("rs_no_rsp", rsp_valid, 2'b00);
    presetn = 1'b1;
    tick();
    chk("rs_no_rsp_after", rsp_valid, 2'b00);
    req_valid = 2'b11;
    req_write = 2'b11;
    #1;
    chk("rs_first_grant", req_ack, 2'b01);
    tick();
    req_valid = 2'b00;
    #1;
    chk("rs_regrant_paddr", paddr, 32'h30);
    tick();
    tick();
    chk("rs_regrant_rsp", rsp_valid, 2'b01);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
